// File: rtl/spi_prog_loader.sv
// Boot-load sequencer: buffers SPI-received instruction words and writes them to
// consecutive ICCM word addresses, then releases the core from reset.
module spi_prog_loader #(
    parameter int unsigned           DATA_WIDTH = 32,
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
    parameter int unsigned           MAX_WORDS  = 4096,
    parameter int unsigned           FIFO_DEPTH = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         en_i,
    input  logic [DATA_WIDTH-1:0]        rx_word_i,
    input  logic                         rx_valid_i,
    output logic                         mem_req_o,
    output logic                         mem_we_o,
    output logic [ADDR_WIDTH-1:0]        mem_addr_o,
    output logic [DATA_WIDTH-1:0]        mem_wdata_o,
    input  logic                         mem_gnt_i,
    input  logic                         mem_rvalid_i,
    output logic                         core_rst_no,
    output logic                         load_done_o,
    output logic [$clog2(MAX_WORDS):0]   word_count_o,
    output logic                         overflow_o
);

    localparam int unsigned CW = $clog2(MAX_WORDS) + 1;
    localparam int unsigned PW = $clog2(FIFO_DEPTH);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] LOAD  = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] RUN   = 2'd3;

    logic [1:0]            r_state;
    logic [DATA_WIDTH-1:0] r_fifo [FIFO_DEPTH];
    logic [PW-1:0]         r_wptr;
    logic [PW-1:0]         r_rptr;
    logic [PW:0]           r_count;
    logic [CW-1:0]         r_idx;
    logic [CW-1:0]         r_widx;
    logic [CW-1:0]         r_wcount;
    logic                  r_outst;
    logic                  r_ovf;

    logic                  w_loading;
    logic                  w_push;
    logic                  w_req;
    logic                  w_pop;

    assign w_loading = (r_state == IDLE) || (r_state == LOAD);
    // Full test uses the registered count: a pop in the same cycle does not make room.
    assign w_push    = rx_valid_i && w_loading
                       && (r_count != (PW+1)'(FIFO_DEPTH))
                       && (r_idx < CW'(MAX_WORDS));
    assign w_req     = (r_count != '0) && !r_outst;
    assign w_pop     = w_req && mem_gnt_i;

    // Request fields derive only from registers, so they stay stable until the grant.
    assign mem_req_o    = w_req;
    assign mem_we_o     = w_req;
    assign mem_addr_o   = BASE_ADDR + (ADDR_WIDTH'(r_widx) << 2);
    assign mem_wdata_o  = w_req ? r_fifo[r_rptr] : '0;
    assign core_rst_no  = (r_state == RUN);
    assign load_done_o  = (r_state == RUN);
    assign word_count_o = r_wcount;
    assign overflow_o   = r_ovf;

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_fifo[r_wptr] <= rx_word_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state  <= IDLE;
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_count  <= '0;
            r_idx    <= '0;
            r_widx   <= '0;
            r_wcount <= '0;
            r_outst  <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (en_i) begin
                        r_state <= DRAIN;
                    end else if (w_push) begin
                        r_state <= LOAD;
                    end
                end
                LOAD: begin
                    if (en_i) begin
                        r_state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if ((r_count == '0) && !r_outst) begin
                        r_state <= RUN;
                    end
                end
                default: r_state <= RUN;
            endcase

            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
                r_idx  <= r_idx + 1'b1;
            end else if (rx_valid_i) begin
                r_ovf <= 1'b1;
            end

            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase

            if (w_pop) begin
                r_rptr  <= r_rptr + 1'b1;
                r_widx  <= r_widx + 1'b1;
                r_outst <= 1'b1;
            end else if (mem_rvalid_i && r_outst) begin
                r_outst  <= 1'b0;
                r_wcount <= r_wcount + 1'b1;
            end
        end
    end

endmodule
